wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter_if.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus between the two requesters, the register-file write port
// and the issue-stage hazard query.
interface wb_port_arbiter_if;
    logic        REQ0_VALID;
    logic [4:0]  REQ0_ADDR;
    logic [31:0] REQ0_DATA;
    logic        REQ0_READY;
    logic        REQ1_VALID;
    logic [4:0]  REQ1_ADDR;
    logic [31:0] REQ1_DATA;
    logic        REQ1_READY;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  Q_A1;
    logic [4:0]  Q_A2;
    logic        BUSY1;
    logic        BUSY2;

    // Arbiter side.
    modport slave (
        input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        input  ISSUE_VALID, ISSUE_RD, Q_A1, Q_A2,
        output REQ0_READY, REQ1_READY,
        output A3, WD3, WE3,
        output BUSY1, BUSY2
    );

    // Requester / register-file / issue-stage side.
    modport master (
        output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        output ISSUE_VALID, ISSUE_RD, Q_A1, Q_A2,
        input  REQ0_READY, REQ1_READY,
        input  A3, WD3, WE3,
        input  BUSY1, BUSY2
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load unit. Optional pending-write scoreboard under `WB_SCOREBOARD_EN.
module wb_port_arbiter (
    input  logic             CLK,
    input  logic             RST_N,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } pri_t;

    pri_t        pri_q;
    pri_t        pri_d;
    logic        grant0;
    logic        grant1;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        grant0    = 1'b0;
        grant1    = 1'b0;
        pri_d     = pri_q;
        xfer_addr = bus.REQ0_ADDR;
        xfer_data = bus.REQ0_DATA;
        if (bus.REQ0_VALID && (!bus.REQ1_VALID || pri_q == PRI_REQ0)) begin
            grant0 = 1'b1;
            pri_d  = PRI_REQ1;
        end else if (bus.REQ1_VALID) begin
            grant1    = 1'b1;
            pri_d     = PRI_REQ0;
            xfer_addr = bus.REQ1_ADDR;
            xfer_data = bus.REQ1_DATA;
        end
    end

    assign bus.REQ0_READY = grant0;
    assign bus.REQ1_READY = grant1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pri_q <= PRI_REQ0;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Registered write port; x0 writes are accepted but never enabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.A3  <= 5'd0;
            bus.WD3 <= 32'd0;
            bus.WE3 <= 1'b0;
        end else if (grant0 || grant1) begin
            bus.A3  <= xfer_addr;
            bus.WD3 <= xfer_data;
            bus.WE3 <= (xfer_addr != 5'd0);
        end else begin
            bus.WE3 <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.ISSUE_VALID) set_vec[bus.ISSUE_RD] = 1'b1;
        if (bus.WE3)         clr_vec[bus.A3]       = 1'b1;
    end

    // NOTE: the busy bits are plain flops, not a RAM, so they take the async
    // reset; outstanding writes are dropped on reset and must not stay busy.
    // Set is OR-ed after the clear so a same-edge issue keeps the bit set;
    // bit 0 is masked so x0 is never busy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
        end
    end

    assign bus.BUSY1 = busy_q[bus.Q_A1];
    assign bus.BUSY2 = busy_q[bus.Q_A2];
`else
    logic unused_sb;
    assign unused_sb = ^{bus.ISSUE_VALID, bus.ISSUE_RD, bus.Q_A1, bus.Q_A2};

    assign bus.BUSY1 = 1'b0;
    assign bus.BUSY2 = 1'b0;
`endif
endmodule
